mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-ported, fixed-latency memory between the pipelined CPU's instruction-fetch side (I) and load/store side (D).
- Sits between the CPU's two memory ports (readM1/address1/data1 and readM2/writeM2/address2/data2) and the memory model.
- Serialises accesses and returns per-side ready pulses that the pipeline uses as stall conditions.

Parameters:
- WORD_SIZE, 16: address and data width.
- MEM_LATENCY, 2: memory cycles per access; must be at least 1.
- CNT_W, 4: latency counter width; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- i_req  input  1  instruction read request; held high until i_ready.
- i_addr  input  WORD_SIZE  fetch address.
- i_rdata  output  WORD_SIZE  fetched word; valid only while i_ready=1.
- i_ready  output  1  one-cycle pulse marking completion of the I access.
- d_read  input  1  load request; held high until d_ready.
- d_write  input  1  store request; held high until d_ready.
- d_addr  input  WORD_SIZE  load/store address.
- d_wdata  input  WORD_SIZE  store data.
- d_rdata  output  WORD_SIZE  load data; valid only while d_ready=1.
- d_ready  output  1  one-cycle pulse marking completion of the D access.
- m_read  output  1  memory read strobe.
- m_write  output  1  memory write strobe.
- m_addr  output  WORD_SIZE  memory address (registered).
- m_wdata  output  WORD_SIZE  memory write data (registered).
- m_rdata  input  WORD_SIZE  memory read data; valid in the final busy cycle.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Counter cnt (CNT_W bits).
- Reset values: state=IDLE, cnt=0, m_read=0, m_write=0, m_addr=0, m_wdata=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0.
- Reset asserted mid-access aborts the access. On the next edge, every strobe is 0 and no ready pulse is issued.
- IDLE, D pending (d_read|d_write) → grant D on the edge:
  - latch m_addr=d_addr; latch m_wdata=d_wdata;
  - set m_write=d_write; set m_read=d_read&~d_write;
  - cnt=MEM_LATENCY-1; next state BUSY_D.
- IDLE, only i_req pending → grant I on the edge: m_addr=i_addr, m_read=1, m_write=0, cnt=MEM_LATENCY-1; next state BUSY_I.
- IDLE, both pending → D wins (fixed priority; see Optional Feature).
- d_read and d_write both high → treated as a write; the read is ignored.
- BUSY_x with cnt>0 → cnt decrements; strobes, m_addr and m_wdata are held. Requester input changes are ignored.
- BUSY_x with cnt==0:
  - x_ready=1 combinationally;
  - x_rdata = m_rdata passthrough, meaning it is a don't-care for D writes;
  - on the edge: state→IDLE, strobes cleared.
- Timing: a request first seen in IDLE at cycle 0 receives ready in cycle MEM_LATENCY. The earliest next grant is cycle MEM_LATENCY+1, giving one access per MEM_LATENCY+1 cycles.
- Requesters drop or change requests on the edge that ends their ready cycle. Because ready is seen in the final busy cycle, the arbiter never re-grants a completed request.
- A request arriving while BUSY waits. It is evaluated in the next IDLE cycle.
- The non-granted side's ready stays 0. i_ready and d_ready are never high together.
- Only the granted side's rdata is meaningful. The other rdata output is 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - a last_grant register is added, reset to I;
  - when both sides are pending in IDLE, grant goes to the side not in last_grant; a single pending side is granted regardless;
  - last_grant updates on every grant;
  - after reset, simultaneous requests grant D first, then I.
- Undefined: fixed D-over-I priority. Continuous D traffic may starve I, which is acceptable because the pipeline stalls fetch during MEM anyway.

Test Plan:
- Reset, then i_req=1, i_addr=0x0010, memory[0x0010]=0x6001, MEM_LATENCY=2:
  - m_read=1 and m_addr=0x0010 in cycles 1-2;
  - i_ready=1 with i_rdata=0x6001 in cycle 2;
  - m_read=0 in cycle 3.
- d_write=1, d_addr=0x0020, d_wdata=0xBEEF; then d_read of 0x0020:
  - m_write=1 for 2 cycles, d_ready pulse;
  - read returns d_rdata=0xBEEF;
  - back-to-back requests spaced 3 cycles apart.
- i_req and d_read asserted in the same cycle, fixed priority: D ready in cycle 2, I granted in cycle 3, I ready in cycle 5. i_ready and d_ready never overlap.
- Change i_addr from 0x0010 to 0x0030 during BUSY_I → m_addr stays 0x0010, and the returned data is the word at 0x0010.
- Assert Reset in cycle 1 of a D write → m_write=0 on the next edge, no d_ready pulse, state IDLE; a fresh i_req then completes normally.
- ARB_ROUND_ROBIN_EN with both requests held continuously → grant order D, I, D, I, with ready pulses every 3 cycles. Without the macro → D only, while d_read stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between CPU fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             d_pend;
    logic             grant_d;
    logic             grant_i;
    logic             last_cycle;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    always_comb begin
        d_pend  = d_read | d_write;
        // On contention, hand the grant to whichever side was not served last.
        grant_d = d_pend & (~i_req | ~last_grant_d);
        grant_i = i_req & ~grant_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            last_grant_d <= 1'b0;
        else if (state == IDLE && (grant_d || grant_i))
            last_grant_d <= grant_d;
    end
`else
    always_comb begin
        d_pend  = d_read | d_write;
        grant_d = d_pend;
        grant_i = i_req & ~grant_d;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_write <= d_write;
                        m_read  <= d_read & ~d_write;
                        cnt     <= CNT_LOAD;
                        state   <= BUSY_D;
                    end else if (grant_i) begin
                        m_addr  <= i_addr;
                        m_read  <= 1'b1;
                        m_write <= 1'b0;
                        cnt     <= CNT_LOAD;
                        state   <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is combinational so the requester sees it in the final busy cycle and drops on that edge.
    always_comb begin
        last_cycle = (cnt == '0);
        i_ready    = (state == BUSY_I) && last_cycle;
        d_ready    = (state == BUSY_D) && last_cycle;
        i_rdata    = i_ready ? m_rdata : '0;
        d_rdata    = d_ready ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected results, a monitor pops on ready.
module tb_mem_port_arbiter;

    localparam int unsigned W = 16;
    localparam int unsigned L = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        bit           chk_data;
        int           t0;
        int           lat_min;
        int           lat_max;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         i_req, d_read, d_write;
    logic [W-1:0] i_addr, d_addr, d_wdata;
    logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic         i_ready, d_ready, m_read, m_write;

    logic [W-1:0] mem     [256];
    logic [W-1:0] ref_mem [256];
    logic         load;
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    bit           sb_en = 1'b0;
    exp_t         iq[$];
    exp_t         dq[$];

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] init_word(input int k);
        logic [7:0] b;
        b = 8'(k);
        if (k == 16) return 16'h6001;
        return {b ^ 8'h5A, b};
    endfunction

    // Memory model: combinational read of the registered address, write on each strobed edge.
    assign m_rdata = mem[m_addr[7:0]];
    always @(posedge Clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
        end else if (m_write) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_lat(input string nm, input int lat, input int lo, input int hi);
        vectors++;
        if (lat < lo || lat > hi) begin
            miscompares++;
            $display("FAIL %s: latency %0d, expected %0d..%0d (cycle %0d)", nm, lat, lo, hi, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready pulse.
    always @(negedge Clk) begin
        exp_t e;
        if (sb_en && !Reset) begin
            if (i_ready && d_ready) chk("ready_overlap", 1, 0);
            if (!i_ready) chk("i_rdata_idle", 32'(i_rdata), 0);
            if (!d_ready) chk("d_rdata_idle", 32'(d_rdata), 0);
            if (i_ready) begin
                if (iq.size() == 0) chk("i_ready_unexpected", 1, 0);
                else begin
                    e = iq.pop_front();
                    chk("i_rdata", 32'(i_rdata), 32'(e.data));
                    chk_lat("i_latency", cyc - e.t0, e.lat_min, e.lat_max);
                end
            end
            if (d_ready) begin
                if (dq.size() == 0) chk("d_ready_unexpected", 1, 0);
                else begin
                    e = dq.pop_front();
                    if (e.chk_data) chk("d_rdata", 32'(d_rdata), 32'(e.data));
                    chk_lat("d_latency", cyc - e.t0, e.lat_min, e.lat_max);
                end
            end
        end
    end

    task automatic wait_ready(input bit side_d, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (side_d ? d_ready : i_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk(nm, 32'(got), 1);
        @(posedge Clk); #1;
    endtask

    // Requester tasks: called just after a rising edge, return just after the edge ending the ready cycle
    // with the request still asserted.
    task automatic do_i(input logic [W-1:0] a, input int lo, input int hi);
        exp_t e;
        i_req = 1'b1;
        i_addr = a;
        e.data = ref_mem[a[7:0]]; e.chk_data = 1'b1; e.t0 = cyc; e.lat_min = lo; e.lat_max = hi;
        iq.push_back(e);
        wait_ready(1'b0, "i_timeout");
    endtask

    task automatic do_d(input bit wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input int lo, input int hi);
        exp_t e;
        d_write = wr;
        d_read = ~wr;
        d_addr = a;
        d_wdata = wd;
        if (wr) ref_mem[a[7:0]] = wd;
        e.data = ref_mem[a[7:0]]; e.chk_data = ~wr; e.t0 = cyc; e.lat_min = lo; e.lat_max = hi;
        dq.push_back(e);
        wait_ready(1'b1, "d_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; load = 1'b1;
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        repeat (2) @(posedge Clk);
        #1 load = 1'b0;
        @(negedge Clk);
        chk("rst_m_read", 32'(m_read), 0);
        chk("rst_m_write", 32'(m_write), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_wdata", 32'(m_wdata), 0);
        chk("rst_ready", 32'({i_ready, d_ready}), 0);
        chk("rst_rdata", 32'(i_rdata | d_rdata), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        sb_en = 1'b1;

        // Single fetch: strobe in cycles 1-2, ready in cycle 2.
        fork
            do_i(16'h0010, L, L);
            begin
                @(negedge Clk);
                chk("f_m_read_c0", 32'(m_read), 0);
                repeat (2) begin
                    @(negedge Clk);
                    chk("f_m_read", 32'(m_read), 1);
                    chk("f_m_addr", 32'(m_addr), 32'h0010);
                end
            end
        join
        i_req = 1'b0;
        chk("f_m_read_c3", 32'(m_read), 0);

        // Store then back-to-back load of the same word.
        fork
            do_d(1'b1, 16'h0020, 16'hBEEF, L, L);
            begin
                @(negedge Clk);
                repeat (2) begin
                    @(negedge Clk);
                    chk("w_m_write", 32'(m_write), 1);
                    chk("w_m_wdata", 32'(m_wdata), 32'hBEEF);
                end
            end
        join
        chk("w_m_write_c3", 32'(m_write), 0);
        do_d(1'b0, 16'h0020, '0, L, L);
        d_read = 1'b0;

        // Simultaneous I and D: D first, I waits one full access plus the idle cycle.
        fork
            begin do_i(16'h0011, 2*L+1, 2*L+1); i_req = 1'b0; end
            begin do_d(1'b0, 16'h0041, '0, L, L); d_read = 1'b0; end
        join

        // Address change during BUSY_I is ignored.
        fork
            do_i(16'h0010, L, L);
            begin
                @(posedge Clk); #2;
                i_addr = 16'h0030;
                repeat (2) begin
                    @(negedge Clk);
                    chk("hold_m_addr", 32'(m_addr), 32'h0010);
                end
            end
        join
        i_req = 1'b0;

        // Reset in the first busy cycle of a store aborts it.
        d_write = 1'b1; d_addr = 16'h007F; d_wdata = 16'h1234;
        @(posedge Clk); #1;
        chk("abort_m_write_c1", 32'(m_write), 1);
        Reset = 1'b1;
        d_write = 1'b0;
        @(posedge Clk); #1;
        chk("abort_m_write", 32'(m_write), 0);
        chk("abort_m_read", 32'(m_read), 0);
        chk("abort_ready", 32'({i_ready, d_ready}), 0);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        do_i(16'h0012, L, L);
        i_req = 1'b0;

        // Both sides held continuously from reset: grant order shows the arbitration policy.
        sb_en = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        i_req = 1'b1; i_addr = 16'h0013;
        d_read = 1'b1; d_addr = 16'h0042;
        for (int k = 0; k <= 12; k++) begin
            bit slot_a, slot_b;
            @(negedge Clk);
            slot_a = (k == L) || (k == 3*L+2);
            slot_b = (k == 2*L+1) || (k == 4*L+3);
            chk("arb_d_ready", 32'(d_ready), 32'(slot_a || (slot_b && !RR)));
            chk("arb_i_ready", 32'(i_ready), 32'(slot_b && RR));
        end
        @(posedge Clk); #1;
        i_req = 1'b0; d_read = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        sb_en = 1'b1;

        // Randomised traffic: fetches from the low region, loads/stores in the upper region.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int unsigned g;
                    do_i(16'($urandom_range(0, 63)), L, 2*L+1);
                    g = $urandom_range(0, 2);
                    if (g != 0) begin
                        i_req = 1'b0;
                        repeat (g) @(posedge Clk);
                        #1;
                    end
                end
                i_req = 1'b0;
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int unsigned g;
                    do_d(1'($urandom_range(0, 1)), 16'(64 + $urandom_range(0, 62)),
                         16'($urandom), L, 2*L+1);
                    d_read = 1'b0; d_write = 1'b0;
                    g = $urandom_range(1, 3);
                    repeat (g) @(posedge Clk);
                    #1;
                end
            end
        join

        repeat (5) @(posedge Clk);
        #1;
        chk("iq_drained", 32'(iq.size()), 0);
        chk("dq_drained", 32'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
